// File: rtl/red_pitaya_sh_trig_ctrl_pkg.sv
// rtl/red_pitaya_sh_trig_ctrl_pkg.sv - shared constants for the sample-and-hold trigger sequencer
//
// Purpose : state encoding, default widths and register-bank offsets used by
//           the sequencer and by the PID bus wrapper for cfg/status access.
// Ports   : none (package).

package red_pitaya_sh_trig_ctrl_pkg;

  localparam int SH_DW = 14;  // trigger sample width
  localparam int SH_CW = 16;  // delay/window/hold-off counter width

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_WINDOW  = 3'd3,
    ST_HOLDOFF = 3'd4
  } sh_state_e;

  // Register offsets within the PID bank
  localparam logic [7:0] REG_SH_CTRL     = 8'h50;  // en, edge, irst
  localparam logic [7:0] REG_SH_THR_HI   = 8'h54;
  localparam logic [7:0] REG_SH_THR_LO   = 8'h58;
  localparam logic [7:0] REG_SH_DLY      = 8'h5C;
  localparam logic [7:0] REG_SH_WIN      = 8'h60;
  localparam logic [7:0] REG_SH_HOFF     = 8'h64;
  localparam logic [7:0] REG_SH_TRIG_CNT = 8'h68;
  localparam logic [7:0] REG_SH_STATUS   = 8'h6C;  // state, miss count

endpackage

// File: rtl/red_pitaya_hyst_cmp.sv
// rtl/red_pitaya_hyst_cmp.sv - registered hysteresis comparator with edge detect
//
// Purpose : registers the trigger sample, derives a hysteretic level from it
//           and flags the selected edge of that level.
// Ports   : clk_i/rst_i    clock, async active-high reset
//           dat_i          trigger sample (signed)
//           thr_hi_i/lo_i  set/clear thresholds (signed)
//           edge_i         0 = rising event, 1 = falling event
//           evt_o          event, valid one cycle after the level changes

module red_pitaya_hyst_cmp
  import red_pitaya_sh_trig_ctrl_pkg::*;
#(
  parameter int DW = SH_DW
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic signed [DW-1:0] dat_i,
  input  logic signed [DW-1:0] thr_hi_i,
  input  logic signed [DW-1:0] thr_lo_i,
  input  logic                 edge_i,
  output logic                 evt_o
);

  logic signed [DW-1:0] dat_q;
  logic                 lvl;
  logic                 lvl_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dat_q <= '0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      dat_q <= dat_i;
      // Set is tested first so it wins when the thresholds are inverted.
      if (dat_q >= thr_hi_i)
        lvl <= 1'b1;
      else if (dat_q <= thr_lo_i)
        lvl <= 1'b0;
      lvl_d <= lvl;
    end
  end

  assign evt_o = edge_i ? (~lvl & lvl_d) : (lvl & ~lvl_d);

endmodule

// File: rtl/red_pitaya_sh_trig_ctrl.sv
// rtl/red_pitaya_sh_trig_ctrl.sv - sample-and-hold trigger sequencer
//
// Purpose : waits for a comparator event, then runs delay -> sample window ->
//           hold-off, driving track/hold, end-of-window strobe and integrator
//           reset of the S&H PID blocks, and keeps trigger/miss statistics.
// Ports   : clk_i, rst_i        clock, async active-high reset
//           dat_trg_i           trigger channel sample
//           cfg_*               configuration from the PID register bank
//           sh_sample_o         1 = track, 0 = hold
//           sh_strobe_o         pulse on the cycle after the window
//           int_rst_o           integrator reset
//           state_o, trig_cnt_o, miss_cnt_o   status readback

module red_pitaya_sh_trig_ctrl
  import red_pitaya_sh_trig_ctrl_pkg::*;
#(
  parameter int DW = SH_DW,
  parameter int CW = SH_CW
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic signed [DW-1:0] dat_trg_i,
  input  logic                 cfg_en_i,
  input  logic                 cfg_edge_i,
  input  logic signed [DW-1:0] cfg_thr_hi_i,
  input  logic signed [DW-1:0] cfg_thr_lo_i,
  input  logic        [CW-1:0] cfg_dly_i,
  input  logic        [CW-1:0] cfg_win_i,
  input  logic        [CW-1:0] cfg_hoff_i,
  input  logic                 cfg_irst_i,
  output logic                 sh_sample_o,
  output logic                 sh_strobe_o,
  output logic                 int_rst_o,
  output logic        [2:0]    state_o,
  output logic        [31:0]   trig_cnt_o,
  output logic        [15:0]   miss_cnt_o
);

  sh_state_e     state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] win_sh;
  logic [CW-1:0] hoff_sh;
  logic [CW-1:0] win_len;
  logic          evt;
  logic          busy;

  red_pitaya_hyst_cmp #(.DW(DW)) i_cmp (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .dat_i    (dat_trg_i),
    .thr_hi_i (cfg_thr_hi_i),
    .thr_lo_i (cfg_thr_lo_i),
    .edge_i   (cfg_edge_i),
    .evt_o    (evt)
  );

  // A zero window still samples for one cycle.
  assign win_len = (cfg_win_i == '0) ? CW'(1) : cfg_win_i;
  assign busy    = (state == ST_DELAY) || (state == ST_WINDOW) || (state == ST_HOLDOFF);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      win_sh      <= '0;
      hoff_sh     <= '0;
      sh_strobe_o <= 1'b0;
      int_rst_o   <= 1'b0;
      trig_cnt_o  <= '0;
      miss_cnt_o  <= '0;
    end else begin
      sh_strobe_o <= 1'b0;
      int_rst_o   <= cfg_irst_i;

      if (evt && busy && (miss_cnt_o != 16'hFFFF))
        miss_cnt_o <= miss_cnt_o + 16'd1;

      if (!cfg_en_i) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            state     <= ST_ARMED;
            int_rst_o <= 1'b1;
          end
          ST_ARMED: begin
            if (evt) begin
              trig_cnt_o <= trig_cnt_o + 32'd1;
              win_sh     <= win_len;
              hoff_sh    <= cfg_hoff_i;
              if (cfg_dly_i != '0) begin
                state <= ST_DELAY;
                cnt   <= cfg_dly_i;
              end else begin
                state <= ST_WINDOW;
                cnt   <= win_len;
              end
            end
          end
          ST_DELAY: begin
            if (cnt == CW'(1)) begin
              state <= ST_WINDOW;
              cnt   <= win_sh;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          ST_WINDOW: begin
            if (cnt == CW'(1)) begin
              sh_strobe_o <= 1'b1;
              if (hoff_sh != '0) begin
                state <= ST_HOLDOFF;
                cnt   <= hoff_sh;
              end else begin
                state <= ST_ARMED;
              end
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          ST_HOLDOFF: begin
            if (cnt == CW'(1))
              state <= ST_ARMED;
            else
              cnt <= cnt - CW'(1);
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Track/hold decoded straight from the state register.
  assign sh_sample_o = (state == ST_WINDOW);
  assign state_o     = state;

endmodule

// File: tb/tb_red_pitaya_sh_trig_ctrl.sv
// tb/tb_red_pitaya_sh_trig_ctrl.sv - self-checking bench for the S&H trigger sequencer

module tb_red_pitaya_sh_trig_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [13:0] dat;
  logic               en, edge_sel, irst;
  logic signed [13:0] thr_hi, thr_lo;
  logic [15:0]        dly, win, hoff;
  logic               sample, strobe, int_rst;
  logic [2:0]         state;
  logic [31:0]        trig_cnt;
  logic [15:0]        miss_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       smp;
    logic       stb;
  } exp_t;

  exp_t sb[$];
  int   hv[5] = '{0, 800, 400, 800, 1200};
  int   nv[3] = '{1100, 600, 1100};

  always #5 clk = ~clk;

  red_pitaya_sh_trig_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .dat_trg_i    (dat),
    .cfg_en_i     (en),
    .cfg_edge_i   (edge_sel),
    .cfg_thr_hi_i (thr_hi),
    .cfg_thr_lo_i (thr_lo),
    .cfg_dly_i    (dly),
    .cfg_win_i    (win),
    .cfg_hoff_i   (hoff),
    .cfg_irst_i   (irst),
    .sh_sample_o  (sample),
    .sh_strobe_o  (strobe),
    .int_rst_o    (int_rst),
    .state_o      (state),
    .trig_cnt_o   (trig_cnt),
    .miss_cnt_o   (miss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_low();
    dat = -14'sd100;
    repeat (4) tick();
  endtask

  task automatic push(input logic [2:0] st, input logic smp, input logic stb);
    exp_t e;
    e.st  = st;
    e.smp = smp;
    e.stb = stb;
    sb.push_back(e);
  endtask

  // Expected per-edge outputs for one trigger cycle, starting at the edge
  // that registers the crossing sample.
  task automatic push_cycle(input int d, input int w, input int h);
    int wl;
    wl = (w == 0) ? 1 : w;
    push(3'd1, 1'b0, 1'b0);
    push(3'd1, 1'b0, 1'b0);
    for (int i = 0; i < d; i++) push(3'd2, 1'b0, 1'b0);
    for (int i = 0; i < wl; i++) push(3'd3, 1'b1, 1'b0);
    if (h > 0) begin
      push(3'd4, 1'b0, 1'b1);
      for (int i = 1; i < h; i++) push(3'd4, 1'b0, 1'b0);
      push(3'd1, 1'b0, 1'b0);
    end else begin
      push(3'd1, 1'b0, 1'b1);
    end
    push(3'd1, 1'b0, 1'b0);
  endtask

  // Pops one expectation per edge; mode 1 injects a second crossing and a
  // window reconfiguration while the cycle is in DELAY.
  task automatic drain(input int mode);
    exp_t e;
    int   i;
    i = 0;
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      chk("sb_state", {29'd0, state}, {29'd0, e.st});
      chk("sb_sample", {31'd0, sample}, {31'd0, e.smp});
      chk("sb_strobe", {31'd0, strobe}, {31'd0, e.stb});
      if (mode == 1) begin
        if (i == 0) dat = -14'sd100;
        else if (i == 1) dat = 14'sd2000;
        else if (i == 2) win = 16'd10;
      end
      i++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; edge_sel = 1'b0; irst = 1'b0;
    thr_hi = 14'sd1000; thr_lo = 14'sd500;
    dly = 16'd0; win = 16'd0; hoff = 16'd0;
    dat = -14'sd100;
    tick(); tick();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_sample", {31'd0, sample}, 32'd0);
    chk("rst_strobe", {31'd0, strobe}, 32'd0);
    chk("rst_irst", {31'd0, int_rst}, 32'd0);
    chk("rst_trig", trig_cnt, 32'd0);
    chk("rst_miss", {16'd0, miss_cnt}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_dis", {29'd0, state}, 32'd0);

    en = 1'b1;
    tick();
    chk("arm_state", {29'd0, state}, 32'd1);
    chk("arm_irst", {31'd0, int_rst}, 32'd1);
    tick();
    chk("arm_irst_end", {31'd0, int_rst}, 32'd0);

    // Basic cycle
    dly = 16'd3; win = 16'd5; hoff = 16'd4;
    dat = 14'sd2000;
    push_cycle(3, 5, 4);
    drain(0);
    chk("basic_trig", trig_cnt, 32'd1);

    // Hysteresis: only the final crossing above thr_hi is an event
    settle_low();
    dly = 16'd0; win = 16'd0; hoff = 16'd0;
    for (int j = 0; j < 5; j++) begin
      dat = 14'(hv[j]);
      repeat (3) tick();
    end
    repeat (4) tick();
    chk("hyst_trig", trig_cnt, 32'd2);
    chk("hyst_state", {29'd0, state}, 32'd1);
    for (int j = 0; j < 3; j++) begin
      dat = 14'(nv[j]);
      repeat (3) tick();
    end
    repeat (3) tick();
    chk("hyst_noevt", trig_cnt, 32'd2);
    chk("hyst_miss", {16'd0, miss_cnt}, 32'd0);

    // Zero-length settings
    settle_low();
    dat = 14'sd2000;
    push_cycle(0, 0, 0);
    drain(0);
    chk("zero_trig", trig_cnt, 32'd3);

    // Missed trigger during DELAY, window latched at trigger
    settle_low();
    dly = 16'd6; win = 16'd3; hoff = 16'd2;
    dat = 14'sd2000;
    push_cycle(6, 3, 2);
    drain(1);
    chk("miss_one", {16'd0, miss_cnt}, 32'd1);
    chk("miss_trig", trig_cnt, 32'd4);

    // Disable mid-window, then re-enable
    settle_low();
    dly = 16'd0; win = 16'd8; hoff = 16'd0;
    dat = 14'sd2000;
    repeat (4) tick();
    chk("dis_inwin", {31'd0, sample}, 32'd1);
    en = 1'b0;
    tick();
    chk("dis_state", {29'd0, state}, 32'd0);
    chk("dis_sample", {31'd0, sample}, 32'd0);
    chk("dis_strobe", {31'd0, strobe}, 32'd0);
    tick();
    chk("dis_strobe2", {31'd0, strobe}, 32'd0);
    en = 1'b1;
    tick();
    chk("reen_state", {29'd0, state}, 32'd1);
    chk("reen_irst", {31'd0, int_rst}, 32'd1);
    tick();
    chk("reen_irst_end", {31'd0, int_rst}, 32'd0);
    chk("dis_trig", trig_cnt, 32'd5);

    // Software integrator reset
    irst = 1'b1;
    tick();
    chk("sw_irst", {31'd0, int_rst}, 32'd1);
    irst = 1'b0;
    tick();
    chk("sw_irst_end", {31'd0, int_rst}, 32'd0);

    // Miss counter saturation: one selected edge per cycle while busy
    settle_low();
    dly = 16'hFFFF; win = 16'hFFFF; hoff = 16'd0;
    dat = 14'sd2000;
    tick(); tick();
    for (int i = 0; i < 65600; i++) begin
      dat      = (i % 2 == 0) ? -14'sd100 : 14'sd2000;
      edge_sel = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick();
    end
    edge_sel = 1'b0;
    dat = -14'sd100;
    chk("sat_miss", {16'd0, miss_cnt}, 32'h0000FFFF);
    chk("sat_trig", trig_cnt, 32'd6);
    chk("sat_state", {29'd0, state}, 32'd3);
    chk("sat_sample", {31'd0, sample}, 32'd1);

    // Asynchronous reset mid-window
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", {29'd0, state}, 32'd0);
    chk("arst_sample", {31'd0, sample}, 32'd0);
    chk("arst_trig", trig_cnt, 32'd0);
    chk("arst_miss", {16'd0, miss_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    en = 1'b0;
    repeat (3) tick();
    chk("arst_idle", {29'd0, state}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
